k16_io_scanner: RTL

- Parametrised successor to the K16 multiplexed I/O block.
- Time-multiplexes CHANNELS 16-bit CPU output words onto a narrow GROUP_WIDTH-bit external bus, using a select address. On the same bus slots it gathers GROUP_WIDTH-bit input groups into CHANNELS 16-bit CPU input words.
- Adds over the previous generation: per-slot dwell time, coherent frame snapshots, a frame-done strobe, and a sticky input-change flag with acknowledge.
- Sits between the K16 CPU I/O registers and the board-level multiplexer/latch hardware.

---
 rtl/k16_io_scanner_if.sv | 26 ++
 rtl/k16_io_scanner.sv | 98 +++++++++
 2 files changed

// File: rtl/k16_io_scanner_if.sv
// k16_io_scanner_if: CPU-side words and external mux bus of the K16 I/O scanner.
interface k16_io_scanner_if #(
    parameter int CHANNELS    = 2,
    parameter int GROUP_WIDTH = 4
);
    localparam int TOTAL = CHANNELS * 16;
    localparam int SLOTS = TOTAL / GROUP_WIDTH;
    localparam int SEL_W = SLOTS > 1 ? $clog2(SLOTS) : 1;
    logic                   enable;
    logic [TOTAL-1:0]       cpu_output;
    logic [TOTAL-1:0]       cpu_input;
    logic [SEL_W-1:0]       select;
    logic [GROUP_WIDTH-1:0] output_bits;
    logic [GROUP_WIDTH-1:0] input_bits;
    logic                   scan_done;
    logic                   input_changed;
    logic                   change_ack;
    modport master (
        output enable, cpu_output, input_bits, change_ack,
        input  cpu_input, select, output_bits, scan_done, input_changed
    );
    modport slave (
        input  enable, cpu_output, input_bits, change_ack,
        output cpu_input, select, output_bits, scan_done, input_changed
    );
endinterface

// File: rtl/k16_io_scanner.sv
// k16_io_scanner: time-multiplexes CPU output words onto a narrow slot bus and
// gathers input groups into coherent per-frame CPU input words.
module k16_io_scanner #(
    parameter int CHANNELS    = 2,
    parameter int GROUP_WIDTH = 4,
    parameter int DWELL       = 2
) (
    input logic             clk,
    input logic             reset,
    k16_io_scanner_if.slave bus
);
    localparam int TOTAL = CHANNELS * 16;
    localparam int SLOTS = TOTAL / GROUP_WIDTH;
    localparam int SEL_W = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam int DW_W  = DWELL > 1 ? $clog2(DWELL) : 1;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t                 state, state_nx;
    logic [SEL_W-1:0]       slot, slot_nx;
    logic [DW_W-1:0]        dwell, dwell_nx;
    logic [TOTAL-1:0]       out_shadow, out_nx;
    logic [TOTAL-1:0]       in_shadow, in_nx;
    logic [TOTAL-1:0]       cpu_in, cin_nx;
    logic [TOTAL-1:0]       merged;
    logic [GROUP_WIDTH-1:0] bits, bits_nx;
    logic                   done, done_nx;
    logic                   changed, chg_nx;
    logic                   start;
    assign bus.select        = slot;
    assign bus.output_bits   = bits;
    assign bus.cpu_input     = cpu_in;
    assign bus.scan_done     = done;
    assign bus.input_changed = changed;
    always_ff @(posedge clk)
        if (!reset) begin
            state      <= IDLE;
            slot       <= '0;
            dwell      <= '0;
            out_shadow <= '0;
            in_shadow  <= '0;
            cpu_in     <= '0;
            bits       <= '0;
            done       <= 1'b0;
            changed    <= 1'b0;
        end else begin
            state      <= state_nx;
            slot       <= slot_nx;
            dwell      <= dwell_nx;
            out_shadow <= out_nx;
            in_shadow  <= in_nx;
            cpu_in     <= cin_nx;
            bits       <= bits_nx;
            done       <= done_nx;
            changed    <= chg_nx;
        end
    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        dwell_nx = dwell;
        out_nx   = out_shadow;
        in_nx    = in_shadow;
        cin_nx   = cpu_in;
        bits_nx  = bits;
        done_nx  = 1'b0;
        chg_nx   = changed & ~bus.change_ack;
        start    = 1'b0;
        // the final group is merged on the frame-end edge so cpu_input is complete
        merged = in_shadow;
        merged[int'(slot)*GROUP_WIDTH +: GROUP_WIDTH] = bus.input_bits;
        if (state == IDLE) begin
            start   = bus.enable;
            bits_nx = '0;
        end else if (dwell != DW_W'(DWELL - 1)) begin
            dwell_nx = dwell + 1'b1;
        end else begin
            dwell_nx = '0;
            in_nx    = merged;
            if (slot != SEL_W'(SLOTS - 1)) begin
                slot_nx = slot + 1'b1;
                bits_nx = GROUP_WIDTH'(out_shadow >> ((int'(slot) + 1) * GROUP_WIDTH));
            end else begin
                cin_nx   = merged;
                done_nx  = 1'b1;
                chg_nx   = chg_nx | (merged != cpu_in);
                slot_nx  = '0;
                bits_nx  = '0;
                state_nx = IDLE;
                start    = bus.enable;
            end
        end
        if (start) begin
            out_nx   = bus.cpu_output;
            slot_nx  = '0;
            dwell_nx = '0;
            bits_nx  = bus.cpu_output[GROUP_WIDTH-1:0];
            state_nx = SCAN;
        end
    end
endmodule
